// File: rtl/flow_hash_gen.sv
// flow_hash_gen: canonicalises a 96-bit flow key to the data direction and
// hashes it with two independent 32-bit CRCs (32 key bits per cycle), then
// hands {is_ack, tuple, index_0, index_1} to the Bloom-filter hash FIFO.
// index_1 is forced to differ from index_0 so the two filter probes never
// land on the same SRAM word.

module flow_hash_gen #(
  parameter int SRAM_ADDR_WIDTH = 19,
  parameter int TUPLE_WIDTH     = 96,
  parameter int CNT_WIDTH       = 32
) (
  input  logic                       clk,
  input  logic                       reset,       // async, active-low
  input  logic [TUPLE_WIDTH-1:0]     in_tuple,
  input  logic                       in_is_ack,
  input  logic                       in_vld,
  output logic                       in_rdy,
  output logic                       is_ack,
  output logic [TUPLE_WIDTH-1:0]     tuple,
  output logic [SRAM_ADDR_WIDTH-1:0] index_0,
  output logic [SRAM_ADDR_WIDTH-1:0] index_1,
  output logic                       out_wr,
  input  logic                       out_rdy,
  output logic [CNT_WIDTH-1:0]       num_hashed,
  output logic [CNT_WIDTH-1:0]       num_collide
);

  localparam logic [31:0] POLY_A   = 32'h04C1_1DB7;
  localparam logic [31:0] POLY_B   = 32'h1EDC_6F41;
  localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;

  localparam logic [CNT_WIDTH-1:0]       CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [SRAM_ADDR_WIDTH-1:0] IDX_ONE = {{(SRAM_ADDR_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_H0   = 3'd1,
    S_H1   = 3'd2,
    S_H2   = 3'd3,
    S_OUT  = 3'd4
  } state_t;

  // One 32-bit-parallel CRC step, MSB of the data word first, no reflection.
  // The loop unrolls into a pure XOR network.
  function automatic logic [31:0] crc32_step(input logic [31:0] crc_in,
                                             input logic [31:0] data,
                                             input logic [31:0] poly);
    logic [31:0] crc;
    logic        fb;
    crc = crc_in;
    for (int i = 31; i >= 0; i--) begin
      fb  = crc[31] ^ data[i];
      crc = {crc[30:0], 1'b0} ^ (fb ? poly : 32'h0);
    end
    return crc;
  endfunction

  // State and datapath registers
  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [TUPLE_WIDTH-1:0]     r_key;
  logic                       r_key_ack;
  logic [31:0]                r_crc_a;
  logic [31:0]                r_crc_b;
  logic                       r_is_ack;
  logic [TUPLE_WIDTH-1:0]     r_tuple;
  logic [SRAM_ADDR_WIDTH-1:0] r_index_0;
  logic [SRAM_ADDR_WIDTH-1:0] r_index_1;
  logic                       r_collide;
  logic [CNT_WIDTH-1:0]       r_num_hashed;
  logic [CNT_WIDTH-1:0]       r_num_collide;

  // Combinational signals
  logic                       w_in_rdy;
  logic                       w_out_wr;
  logic                       w_accept;
  logic [TUPLE_WIDTH-1:0]     w_canon_key;
  logic [31:0]                w_word;
  logic [31:0]                w_crc_a_nxt;
  logic [31:0]                w_crc_b_nxt;
  logic [SRAM_ADDR_WIDTH-1:0] w_index_0;
  logic [SRAM_ADDR_WIDTH-1:0] w_raw1;
  logic [SRAM_ADDR_WIDTH-1:0] w_index_1;
  logic                       w_collide;

  // An ACK travels the reverse direction: swap IPs and ports so both
  // directions of a flow hash to the same filter entries.
  assign w_canon_key = in_is_ack
                     ? {in_tuple[63:32], in_tuple[95:64], in_tuple[15:0], in_tuple[31:16]}
                     : in_tuple;

  assign w_accept = w_in_rdy & in_vld;

  // Select the key word hashed in the current H state.
  always_comb begin
    w_word = r_key[95:64];
    unique case (r_state)
      S_H1:    w_word = r_key[63:32];
      S_H2:    w_word = r_key[31:0];
      default: w_word = r_key[95:64];
    endcase
  end

  assign w_crc_a_nxt = crc32_step(r_crc_a, w_word, POLY_A);
  assign w_crc_b_nxt = crc32_step(r_crc_b, w_word, POLY_B);

  // Final indices are taken from the CRC values produced in H2.
  assign w_index_0 = ~w_crc_a_nxt[SRAM_ADDR_WIDTH-1:0];
  assign w_raw1    = ~w_crc_b_nxt[SRAM_ADDR_WIDTH-1:0];
  assign w_collide = (w_raw1 == w_index_0);
  assign w_index_1 = w_collide ? (w_raw1 ^ IDX_ONE) : w_raw1;

  // FSM state register.
  // NOTE: clocked blocks use non-blocking (<=) so every register samples
  // pre-edge values; blocking (=) here would create order-dependent races.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next-state and handshake outputs.
  // NOTE: every output of this block gets a default first; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_in_rdy    = 1'b0;
    w_out_wr    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_in_rdy = 1'b1;
        if (in_vld) w_state_nxt = S_H0;
      end
      S_H0: w_state_nxt = S_H1;
      S_H1: w_state_nxt = S_H2;
      S_H2: w_state_nxt = S_OUT;
      S_OUT: begin
        w_out_wr = out_rdy;
        if (out_rdy) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Latch the canonical key and its ACK flag when a key is accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_key     <= '0;
      r_key_ack <= 1'b0;
    end else if (w_accept) begin
      r_key     <= w_canon_key;
      r_key_ack <= in_is_ack;
    end
  end

  // CRC accumulators: seeded on accept, stepped once per H state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_crc_a <= CRC_INIT;
      r_crc_b <= CRC_INIT;
    end else if (w_accept) begin
      r_crc_a <= CRC_INIT;
      r_crc_b <= CRC_INIT;
    end else if (r_state == S_H0 || r_state == S_H1 || r_state == S_H2) begin
      r_crc_a <= w_crc_a_nxt;
      r_crc_b <= w_crc_b_nxt;
    end
  end

  // Result registers: loaded on the H2->OUT edge, held through OUT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_is_ack  <= 1'b0;
      r_tuple   <= '0;
      r_index_0 <= '0;
      r_index_1 <= '0;
      r_collide <= 1'b0;
    end else if (r_state == S_H2) begin
      r_is_ack  <= r_key_ack;
      r_tuple   <= r_key;
      r_index_0 <= w_index_0;
      r_index_1 <= w_index_1;
      r_collide <= w_collide;
    end
  end

  // Statistics: both counters move on the edge that ends the out_wr cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_num_hashed  <= '0;
      r_num_collide <= '0;
    end else if (w_out_wr) begin
      r_num_hashed <= r_num_hashed + CNT_ONE;
      if (r_collide && (r_num_collide != '1)) r_num_collide <= r_num_collide + CNT_ONE;
    end
  end

  assign in_rdy      = w_in_rdy;
  assign out_wr      = w_out_wr;
  assign is_ack      = r_is_ack;
  assign tuple       = r_tuple;
  assign index_0     = r_index_0;
  assign index_1     = r_index_1;
  assign num_hashed  = r_num_hashed;
  assign num_collide = r_num_collide;

endmodule

// File: tb/tb_flow_hash_gen.sv
// tb_flow_hash_gen: directed vector table plus hand-written sequences for
// reset, backpressure, collision/saturation and back-to-back acceptance.
// Expected hashes come from a word-XOR-then-shift CRC reference model.

module tb_flow_hash_gen;

  localparam int AW = 19;
  localparam int CW = 8;
  localparam logic [31:0] PA = 32'h04C1_1DB7;
  localparam logic [31:0] PB = 32'h1EDC_6F41;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [95:0]   in_tuple = '0;
  logic          in_is_ack = 1'b0;
  logic          in_vld = 1'b0;
  logic          in_rdy;
  logic          is_ack;
  logic [95:0]   tuple;
  logic [AW-1:0] index_0;
  logic [AW-1:0] index_1;
  logic          out_wr;
  logic          out_rdy = 1'b1;
  logic [CW-1:0] num_hashed;
  logic [CW-1:0] num_collide;

  flow_hash_gen #(.SRAM_ADDR_WIDTH(AW), .TUPLE_WIDTH(96), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .in_tuple(in_tuple), .in_is_ack(in_is_ack),
    .in_vld(in_vld), .in_rdy(in_rdy), .is_ack(is_ack), .tuple(tuple),
    .index_0(index_0), .index_1(index_1), .out_wr(out_wr), .out_rdy(out_rdy),
    .num_hashed(num_hashed), .num_collide(num_collide)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int exp_hashed = 0;
  int exp_collide = 0;
  int consec_err = 0;

  typedef struct {
    logic [95:0]   t;
    logic          a;
    logic [AW-1:0] i0;
    logic [AW-1:0] i1;
  } rec_t;
  rec_t mon_q[$];
  logic prev_wr = 1'b0;

  // Record every write strobe as it is sampled by the FIFO.
  always @(posedge clk) begin
    if (out_wr) begin
      rec_t r;
      r.t = tuple; r.a = is_ack; r.i0 = index_0; r.i1 = index_1;
      mon_q.push_back(r);
      if (prev_wr) consec_err++;
    end
    prev_wr = out_wr;
  end

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference CRC: XOR the whole word into the register, then 32 shifts.
  function automatic logic [31:0] m_crc(input logic [95:0] k, input logic [31:0] poly);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int w = 0; w < 3; w++) begin
      c = c ^ k[95-32*w -: 32];
      for (int b = 0; b < 32; b++) c = c[31] ? ((c << 1) ^ poly) : (c << 1);
    end
    return c;
  endfunction

  function automatic logic [AW-1:0] m_idx0(input logic [95:0] k);
    logic [31:0] x;
    x = ~m_crc(k, PA);
    return x[AW-1:0];
  endfunction

  function automatic logic [AW-1:0] m_raw1(input logic [95:0] k);
    logic [31:0] x;
    x = ~m_crc(k, PB);
    return x[AW-1:0];
  endfunction

  function automatic logic [AW-1:0] m_idx1(input logic [95:0] k);
    logic [AW-1:0] r;
    r = m_raw1(k);
    if (r == m_idx0(k)) r = r ^ 19'd1;
    return r;
  endfunction

  function automatic logic [AW-1:0] m_diff(input logic [95:0] k);
    logic [31:0] x;
    x = m_crc(k, PA) ^ m_crc(k, PB);
    return x[AW-1:0];
  endfunction

  function automatic logic [95:0] m_canon(input logic [95:0] t, input logic a);
    return a ? {t[63:32], t[95:64], t[15:0], t[31:16]} : t;
  endfunction

  // Offer one key from IDLE with out_rdy high; return what was emitted.
  task automatic run_key(input logic [95:0] t, input logic a,
                         output logic [95:0] o_t, output logic o_a,
                         output logic [AW-1:0] o_i0, output logic [AW-1:0] o_i1);
    int n;
    logic [95:0] ck;
    n = 0;
    while (!in_rdy && n < 20) begin @(negedge clk); n++; end
    check("in_rdy_before_key", in_rdy, 1'b1);
    in_tuple = t; in_is_ack = a; in_vld = 1'b1;
    @(negedge clk);
    in_vld = 1'b0;
    n = 1;
    while (!out_wr && n < 20) begin @(negedge clk); n++; end
    check("out_wr_latency", n, 4);
    o_t = tuple; o_a = is_ack; o_i0 = index_0; o_i1 = index_1;
    @(negedge clk);
    ck = m_canon(t, a);
    exp_hashed = (exp_hashed + 1) % 256;
    if (m_raw1(ck) == m_idx0(ck) && exp_collide < 255) exp_collide++;
  endtask

  typedef struct {
    logic [95:0]   t;
    logic          a;
    logic [95:0]   exp_t;
    logic [AW-1:0] exp_i0;
    logic [AW-1:0] exp_i1;
  } vec_t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t          vecs[5];
    logic [95:0]   gt;
    logic          ga;
    logic [AW-1:0] g0, g1, d0, d1;
    logic [AW-1:0] e0, e1;
    logic [95:0]   ck;
    logic [95:0]   bk[3];
    logic          bk_a[3];
    int            wc, base_q, k, cyc, last_acc;

    vecs[0] = '{96'h0A000001_0A000002_1F90_C350, 1'b0, 96'h0A000001_0A000002_1F90_C350, '0, '0};
    vecs[1] = '{96'h0A000002_0A000001_C350_1F90, 1'b1, 96'h0A000001_0A000002_1F90_C350, '0, '0};
    vecs[2] = '{96'h0, 1'b0, 96'h0, '0, '0};
    vecs[3] = '{{96{1'b1}}, 1'b1, {96{1'b1}}, '0, '0};
    vecs[4] = '{96'hC0A80101_08080808_0035_D431, 1'b1, 96'h08080808_C0A80101_D431_0035, '0, '0};
    foreach (vecs[i]) begin
      vecs[i].exp_i0 = m_idx0(vecs[i].exp_t);
      vecs[i].exp_i1 = m_idx1(vecs[i].exp_t);
    end

    // Reset state
    @(negedge clk); @(negedge clk);
    check("rst_in_rdy", in_rdy, 1'b1);
    check("rst_out_wr", out_wr, 1'b0);
    check("rst_is_ack", is_ack, 1'b0);
    check("rst_tuple", tuple, 96'h0);
    check("rst_index_0", index_0, 19'h0);
    check("rst_index_1", index_1, 19'h0);
    check("rst_num_hashed", num_hashed, 8'h0);
    check("rst_num_collide", num_collide, 8'h0);
    reset = 1'b1;
    @(negedge clk);

    // Directed vector table
    d0 = '0; d1 = '0;
    for (int i = 0; i < 5; i++) begin
      run_key(vecs[i].t, vecs[i].a, gt, ga, g0, g1);
      check($sformatf("vec%0d_tuple", i), gt, vecs[i].exp_t);
      check($sformatf("vec%0d_is_ack", i), ga, vecs[i].a);
      check($sformatf("vec%0d_index_0", i), g0, vecs[i].exp_i0);
      check($sformatf("vec%0d_index_1", i), g1, vecs[i].exp_i1);
      check($sformatf("vec%0d_idx_distinct", i), (g0 != g1), 1'b1);
      if (i == 0) begin d0 = g0; d1 = g1; end
      if (i == 1) begin
        check("dir_match_index_0", g0, d0);
        check("dir_match_index_1", g1, d1);
      end
    end
    check("vec_num_hashed", num_hashed, exp_hashed[CW-1:0]);

    // Backpressure, with out_rdy toggling during hashing
    ck = 96'hDEADBEEF_01020304_ABCD_1234;
    e0 = m_idx0(m_canon(ck, 1'b1));
    e1 = m_idx1(m_canon(ck, 1'b1));
    out_rdy = 1'b0;
    in_tuple = ck; in_is_ack = 1'b1; in_vld = 1'b1;
    @(negedge clk); in_vld = 1'b0; out_rdy = 1'b1;
    @(negedge clk); out_rdy = 1'b0;
    check("bp_no_wr_in_h1", out_wr, 1'b0);
    @(negedge clk);
    @(negedge clk);
    wc = mon_q.size();
    for (int c = 0; c < 10; c++) begin
      check("bp_out_wr_low", out_wr, 1'b0);
      check("bp_in_rdy_low", in_rdy, 1'b0);
      check("bp_tuple_held", tuple, 96'h01020304_DEADBEEF_1234_ABCD);
      check("bp_index_0_held", index_0, e0);
      check("bp_index_1_held", index_1, e1);
      @(negedge clk);
    end
    out_rdy = 1'b1;
    #1;
    check("bp_release_out_wr", out_wr, 1'b1);
    @(negedge clk);
    exp_hashed = (exp_hashed + 1) % 256;
    check("bp_idle_after", in_rdy, 1'b1);
    check("bp_single_wr", mon_q.size(), wc + 1);
    check("bp_num_hashed", num_hashed, exp_hashed[CW-1:0]);

    // Reset asserted mid-hash (in H1)
    in_tuple = 96'h11111111_22222222_3333_4444; in_is_ack = 1'b0; in_vld = 1'b1;
    @(negedge clk); in_vld = 1'b0;
    @(negedge clk);
    wc = mon_q.size();
    reset = 1'b0;
    #1;
    check("midrst_in_rdy", in_rdy, 1'b1);
    check("midrst_out_wr", out_wr, 1'b0);
    check("midrst_tuple", tuple, 96'h0);
    check("midrst_index_0", index_0, 19'h0);
    check("midrst_index_1", index_1, 19'h0);
    check("midrst_is_ack", is_ack, 1'b0);
    check("midrst_num_hashed", num_hashed, 8'h0);
    @(negedge clk);
    reset = 1'b1;
    exp_hashed = 0; exp_collide = 0;
    repeat (8) @(negedge clk);
    check("midrst_no_wr", mon_q.size(), wc);
    check("midrst_idle", in_rdy, 1'b1);

    // Golden random keys
    for (int i = 0; i < 100; i++) begin
      logic [95:0] rk;
      logic        ra;
      rk = {$urandom, $urandom, $urandom};
      ra = 1'($urandom_range(0, 1));
      run_key(rk, ra, gt, ga, g0, g1);
      check("gold_tuple", gt, m_canon(rk, ra));
      check("gold_index_0", g0, m_idx0(m_canon(rk, ra)));
      check("gold_index_1", g1, m_idx1(m_canon(rk, ra)));
    end
    check("gold_num_hashed", num_hashed, 8'd100);
    check("gold_num_collide", num_collide, exp_collide[CW-1:0]);

    // Collision: search an affine slice of the key space for raw1 == index_0
    begin
      logic [AW-1:0] cols[24];
      logic [AW-1:0] acc;
      logic [95:0]   base;
      bit            found;
      base = 96'h01234567_89ABCDEF_5555_0000;
      acc = m_diff(base);
      for (int j = 0; j < 24; j++) begin
        logic [95:0] e;
        e = 96'd1 << j;
        cols[j] = m_diff(base ^ e) ^ acc;
      end
      ck = base;
      found = (acc == '0);
      for (int g = 1; g < (1 << 24) && !found; g++) begin
        int tz;
        tz = 0;
        while (((g >> tz) & 1) == 0) tz++;
        ck[tz] = ~ck[tz];
        acc = acc ^ cols[tz];
        if (acc == '0) found = 1'b1;
      end
      check("coll_key_found", found, 1'b1);
    end
    run_key(ck, 1'b0, gt, ga, g0, g1);
    check("coll_index_0", g0, m_idx0(ck));
    check("coll_index_1", g1, m_idx0(ck) ^ 19'd1);
    check("coll_num_collide", num_collide, exp_collide[CW-1:0]);
    for (int r = 0; r < 260; r++) run_key(ck, 1'b0, gt, ga, g0, g1);
    check("coll_saturated", num_collide, 8'hFF);
    check("hashed_wrapped", num_hashed, exp_hashed[CW-1:0]);

    // Back-to-back with in_vld held high
    for (int i = 0; i < 3; i++) begin
      bk[i] = {$urandom, $urandom, $urandom};
      bk_a[i] = 1'(i == 1);
    end
    base_q = mon_q.size();
    in_vld = 1'b1; k = 0; cyc = 0; last_acc = 0;
    while (cyc < 60 && (k < 3 || mon_q.size() < base_q + 3)) begin
      if (in_rdy && k < 3) begin
        in_tuple = bk[k]; in_is_ack = bk_a[k];
        if (k > 0) check("b2b_interval", cyc - last_acc, 5);
        last_acc = cyc;
        k++;
      end else if (k == 3) begin
        in_vld = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    in_vld = 1'b0;
    check("b2b_accepted", k, 3);
    check("b2b_pulses", mon_q.size(), base_q + 3);
    for (int i = 0; i < 3; i++) begin
      if (base_q + i < mon_q.size()) begin
        check("b2b_tuple", mon_q[base_q+i].t, m_canon(bk[i], bk_a[i]));
        check("b2b_is_ack", mon_q[base_q+i].a, bk_a[i]);
        check("b2b_index_0", mon_q[base_q+i].i0, m_idx0(m_canon(bk[i], bk_a[i])));
        check("b2b_index_1", mon_q[base_q+i].i1, m_idx1(m_canon(bk[i], bk_a[i])));
      end
      exp_hashed = (exp_hashed + 1) % 256;
    end
    repeat (3) @(negedge clk);
    check("b2b_num_hashed", num_hashed, exp_hashed[CW-1:0]);
    check("no_consecutive_out_wr", consec_err, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/flow_hash_gen.md
# flow_hash_gen

Upstream stage of the Bloom-filter latency path. Accepts one parsed 5-tuple-less flow key (2×IPv4 + 2×port, 96 bits) per packet plus a data/ACK flag, canonicalises ACK keys to data direction, and computes two independent 32-bit CRC hashes iteratively, 32 bits per cycle. It emits `{is_ack, tuple, index_0, index_1}` into the Bloom-filter hash FIFO through that block's `in_wr`/`in_rdy` pair.

## Interface
- SRAM_ADDR_WIDTH, 19, width of each emitted index
- TUPLE_WIDTH, 96, flow key width (fixed layout, see Operation)
- CNT_WIDTH, 32, width of statistics counters
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- in_tuple  in  96  {src_ip[95:64], dst_ip[63:32], src_port[31:16], dst_port[15:0]}
- in_is_ack  in  1  key comes from an ACK packet
- in_vld  in  1  key valid
- in_rdy  out  1  block can accept a key this cycle
- is_ack  out  1  registered copy of in_is_ack
- tuple  out  96  canonical (data-direction) key
- index_0  out  SRAM_ADDR_WIDTH  hash 0 address
- index_1  out  SRAM_ADDR_WIDTH  hash 1 address, always ≠ index_0
- out_wr  out  1  write strobe into downstream FIFO
- out_rdy  in  1  downstream not full
- num_hashed  out  CNT_WIDTH  keys emitted, wraps
- num_collide  out  CNT_WIDTH  keys where raw index_1 == index_0, saturates

## Operation
- States: IDLE, H0, H1, H2, OUT (one-hot or binary, implementer's choice).
- IDLE: in_rdy=1. On in_vld: latch key, latch in_is_ack, init crc_a=crc_b=32'hFFFFFFFF, go H0.
- Canonicalisation at latch: if in_is_ack, key = {dst_ip, src_ip, dst_port, src_port}; else key unchanged. `tuple` outputs the canonical key.
- H0/H1/H2: process key word [95:64], [63:32], [31:0] respectively, MSB-first, one 32-bit-parallel CRC step per cycle. crc_a polynomial 0x04C11DB7, crc_b polynomial 0x1EDC6F41, no reflection. H2 → OUT.
- Final: index_0 = ~crc_a[SRAM_ADDR_WIDTH-1:0]; raw1 = ~crc_b[SRAM_ADDR_WIDTH-1:0]; if raw1 == index_0 then index_1 = raw1 ^ 1 and num_collide increments (saturating at all-ones), else index_1 = raw1. Outputs registered on the H2→OUT edge and held stable throughout OUT.
- OUT: out_wr = out_rdy (combinational). When out_rdy=1: num_hashed +1 (wraps), go IDLE. When out_rdy=0: remain in OUT, outputs held, out_wr=0.
- in_rdy=0 in every state except IDLE; in_vld is ignored outside IDLE (upstream must hold).

## Timing
- Reset (reset=0, async): state=IDLE, is_ack=0, tuple=0, index_0=0, index_1=0, num_hashed=0, num_collide=0, CRC regs=FFFFFFFF; out_wr=0, in_rdy=1 combinationally after reset. Reset asserted mid-hash (any state) discards the key; no out_wr is produced for it.
- Latency: key accepted at edge N → H0 at N, H1 N+1, H2 N+2, OUT from edge N+3; out_wr high in cycle N+3 if out_rdy. Min interval 5 cycles per key (IDLE cycle included).
- out_wr never asserted two consecutive cycles; exactly one out_wr per accepted key.
- Counters update on the edge ending the out_wr cycle; visible the following cycle.
- out_rdy toggling during H0–H2 has no effect.

## Test plan
- Reset: drive reset=0 mid-H1 with a key loaded -> all outputs return to reset values immediately, in_rdy=1, no out_wr ever for that key.
- Direction match: data key 0x0A000001_0A000002_1F90_C350 (is_ack=0) then ACK key 0x0A000002_0A000001_C350_1F90 (is_ack=1) -> identical tuple, index_0, index_1 on both; is_ack 0 then 1; out_wr 4 cycles after each accept.
- Golden hashes: 100 random keys vs C model of both CRCs -> every index_0/index_1 matches, num_hashed=100.
- Backpressure: hold out_rdy=0 for 10 cycles in OUT -> out_wr=0, outputs stable, in_rdy=0; release -> single out_wr, IDLE next cycle.
- Collision: key chosen (from C model search) so raw1==index_0 -> index_1 = index_0^1, num_collide=1; pre-load num_collide to all-ones via repeat -> stays all-ones.
- Back-to-back: in_vld held high with 3 keys -> accepts on every 5th cycle, 3 out_wr pulses, no key lost or duplicated.
